// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the 8-point FFT frame sequencer.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    BF1  = 3'd2,
    BF2  = 3'd3,
    BF3  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int N_POINTS = 8;
  // Sample counter must reach N_POINTS-1+ROM_LAT (at most 8).
  localparam int CNT_W    = 4;

  // Last sample-counter value of the LOAD phase for a given ROM latency.
  function automatic int load_last(input int rom_lat);
    return N_POINTS - 1 + rom_lat;
  endfunction

endpackage

// File: rtl/fft_seq_addr_gen.sv
// ROM address counter plus the ROM-latency delay line that turns the
// address-issue strobe into the datapath serial-to-parallel shift enable.
module fft_seq_addr_gen
  import fft_seq_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              en_s2p
);

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (inc) begin
      rom_addr <= rom_addr + ADDR_W'(1);  // natural wrap modulo 2^ADDR_W
    end
  end

  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign en_s2p = inc & ~clear;
    end else begin : g_lat1
      logic issue_q;
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          issue_q <= 1'b0;
        end else begin
          issue_q <= inc;
        end
      end
      assign en_s2p = issue_q;
    end
  endgenerate

endmodule

// File: rtl/fft_8p_sequencer.sv
// Frame-level handshaking sequencer for the 8-point FFT datapath.
// Optional status counters (frame_cnt, abort_cnt) are built when FFT_SEQ_STATUS_EN is defined.
module fft_8p_sequencer
  import fft_seq_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              en_s2p,
  output logic              en_bf1_1,
  output logic              en_bf1_2,
  output logic              en_bf1_3,
  output logic              en_bf1_4,
  output logic              en_bf2_1,
  output logic              en_bf2_2,
  output logic              en_bf3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef FFT_SEQ_STATUS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int LOAD_LAST = load_last(ROM_LAT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             inc;

  // Abort blocks acceptance so a same-cycle start is dropped.
  assign start_ready = !abort && ((state == IDLE) || (state == DONE && out_ready));
  assign accept      = start_valid && start_ready;
  // Address issues on counter 0..7; an abort freezes the address where it is.
  assign inc         = (state == LOAD) && (cnt < CNT_W'(N_POINTS)) && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == LOAD && state_n == LOAD) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n   = state;
    en_bf1_1  = 1'b0;
    en_bf1_2  = 1'b0;
    en_bf1_3  = 1'b0;
    en_bf1_4  = 1'b0;
    en_bf2_1  = 1'b0;
    en_bf2_2  = 1'b0;
    en_bf3    = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (accept) state_n = LOAD;
      LOAD: if (cnt == CNT_W'(LOAD_LAST)) state_n = BF1;
      BF1: begin
        en_bf1_1 = 1'b1;
        en_bf1_2 = 1'b1;
        en_bf1_3 = 1'b1;
        en_bf1_4 = 1'b1;
        state_n  = BF2;
      end
      BF2: begin
        en_bf2_1 = 1'b1;
        en_bf2_2 = 1'b1;
        state_n  = BF3;
      end
      BF3: begin
        en_bf3  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (accept)         state_n = LOAD;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  fft_seq_addr_gen #(
    .ADDR_W  (ADDR_W),
    .ROM_LAT (ROM_LAT)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .clear    (abort),
    .rom_addr (rom_addr),
    .en_s2p   (en_s2p)
  );

`ifdef FFT_SEQ_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (out_valid && out_ready && !abort) frame_cnt <= frame_cnt + 16'd1;
      if (abort && busy && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule
